// File: rtl/aes_mode_sequencer.sv
// Multi-channel ECB/CBC/CTR chaining front end around a single cipher core, with an output FIFO.
// Optional core watchdog enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_mode_sequencer #(
    parameter int NCH        = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CTR_W      = 32,
    parameter int TIMEOUT    = 64,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           CLK,
    input  logic           CLR_N,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [1:0]     cfg_mode,
    input  logic           cfg_enc_dec,
    input  logic [127:0]   cfg_iv,
    output logic           cfg_err,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  logic [127:0]   in_data,
    output logic           core_go,
    output logic           core_enc_dec,
    output logic [127:0]   core_state_i,
    input  logic [127:0]   core_state_o,
    input  logic           core_CF,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CHW-1:0] out_ch,
    output logic [127:0]   out_data,
    output logic           busy,
    output logic           timeout
);

    localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam logic [1:0] M_ECB = 2'b00;
    localparam logic [1:0] M_CBC = 2'b01;
    localparam logic [1:0] M_CTR = 2'b10;
    localparam logic [127:0] CTR_MASK = (128'd1 << CTR_W) - 128'd1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_POST} state_e;

    state_e           state_q, state_d;
    logic [1:0]       mode_q  [NCH];
    logic             dir_q   [NCH];
    logic [127:0]     chain_q [NCH];

    logic [CHW-1:0]   ch_q;
    logic             chok_q;
    logic [1:0]       mode_op_q;
    logic             dir_op_q;
    logic [127:0]     cin_q;
    logic [127:0]     data_q;
    logic [127:0]     res_q;
    logic             cfg_err_q;

    logic [127:0]     fifo_data_q [FIFO_DEPTH];
    logic [CHW-1:0]   fifo_ch_q   [FIFO_DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]  count_q;

    logic             acc, push, pop, upd;
    logic             in_chok, cfg_chok, cfg_rej, cfg_ok;
    logic [1:0]       in_mode;
    logic             in_dir, acc_dir;
    logic [127:0]     in_chain, acc_cin;
    logic [127:0]     chain_cur, chain_nxt, post_out;

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0]   wd_q;
    logic             wd_exp;
    logic             timeout_q;
`endif

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        if (int'(p) == FIFO_DEPTH - 1) return '0;
        return p + PTRW'(1);
    endfunction

    assign busy      = (state_q != S_IDLE);
    assign core_go   = (state_q == S_ISSUE);
    assign core_enc_dec = dir_op_q;
    assign core_state_i = cin_q;
    assign cfg_err   = cfg_err_q;
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_ch    = out_valid ? fifo_ch_q[rd_ptr_q] : '0;

    assign in_chok  = (int'(in_ch) < NCH);
    assign cfg_chok = (int'(cfg_ch) < NCH);
    assign in_ready = (state_q == S_IDLE) && (count_q != CNTW'(FIFO_DEPTH)) &&
                      !(cfg_we && (cfg_ch == in_ch));
    assign acc      = in_valid && in_ready;
    // Only the in-flight channel is locked; every other channel stays writable while busy.
    assign cfg_rej  = cfg_we && (!cfg_chok || (busy && (cfg_ch == ch_q)));
    assign cfg_ok   = cfg_we && !cfg_rej;
    assign push     = (state_q == S_POST);
    assign pop      = out_valid && out_ready;
    assign upd      = push && chok_q && (mode_op_q != M_ECB);

    always_comb begin
        in_mode  = M_ECB;
        in_dir   = 1'b1;
        in_chain = '0;
        if (in_chok) begin
            in_dir   = dir_q[in_ch];
            in_chain = chain_q[in_ch];
            if (mode_q[in_ch] == M_CBC || mode_q[in_ch] == M_CTR) in_mode = mode_q[in_ch];
        end
        acc_dir = in_dir;
        acc_cin = in_data;
        case (in_mode)
            M_CBC:   if (in_dir) acc_cin = in_data ^ in_chain;
            M_CTR:   begin
                acc_cin = in_chain;
                acc_dir = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        chain_cur = chok_q ? chain_q[ch_q] : '0;
        post_out  = res_q;
        chain_nxt = chain_cur;
        case (mode_op_q)
            M_CBC: begin
                if (dir_op_q) begin
                    chain_nxt = res_q;
                end else begin
                    post_out  = res_q ^ chain_cur;
                    chain_nxt = data_q;
                end
            end
            M_CTR: begin
                post_out  = res_q ^ data_q;
                chain_nxt = ((chain_cur + 128'd1) & CTR_MASK) | (chain_cur & ~CTR_MASK);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
`ifdef AES_SEQ_TIMEOUT_EN
        wd_exp  = 1'b0;
`endif
        case (state_q)
            S_IDLE:  if (acc) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (core_CF) begin
                    state_d = S_POST;
                end
`ifdef AES_SEQ_TIMEOUT_EN
                else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    wd_exp  = 1'b1;
                end
`endif
            end
            S_POST:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            chok_q    <= 1'b0;
            mode_op_q <= M_ECB;
            dir_op_q  <= 1'b0;
            cin_q     <= '0;
            cfg_err_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= cfg_rej;
            if (acc) begin
                ch_q      <= in_ch;
                chok_q    <= in_chok;
                mode_op_q <= in_mode;
                dir_op_q  <= acc_dir;
                cin_q     <= acc_cin;
            end
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            for (int i = 0; i < NCH; i++) begin
                mode_q[i]  <= M_ECB;
                dir_q[i]   <= 1'b1;
                chain_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_ok && int'(cfg_ch) == i) begin
                    mode_q[i]  <= cfg_mode;
                    dir_q[i]   <= cfg_enc_dec;
                    chain_q[i] <= cfg_iv;
                end else if (upd && int'(ch_q) == i) begin
                    chain_q[i] <= chain_nxt;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (acc) data_q <= in_data;
        if (state_q == S_WAIT && core_CF) res_q <= core_state_o;
        if (push) begin
            fifo_data_q[wr_ptr_q] <= post_out;
            fifo_ch_q[wr_ptr_q]   <= ch_q;
        end
    end

`ifdef AES_SEQ_TIMEOUT_EN
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= (state_q == S_WAIT) ? wd_q + WDW'(1) : '0;
            timeout_q <= wd_exp;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_aes_mode_sequencer.sv
// Scoreboard bench for aes_mode_sequencer with a behavioural cipher core stand-in.
module tb_aes_mode_sequencer;

    localparam int CHW = 1;
    localparam int NCH = 2;
    localparam logic [127:0] KAT_P = 128'h2054776F4E696E654F6E652054776F20;
    localparam logic [127:0] KAT_C = 128'h1A02D73A402299B3571420F629C3505F;
    localparam logic [127:0] TOY_K = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

    logic           CLK;
    logic           CLR_N;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [1:0]     cfg_mode;
    logic           cfg_enc_dec;
    logic [127:0]   cfg_iv;
    logic           cfg_err;
    logic           in_valid;
    logic           in_ready;
    logic [CHW-1:0] in_ch;
    logic [127:0]   in_data;
    logic           core_go;
    logic           core_enc_dec;
    logic [127:0]   core_state_i;
    logic [127:0]   core_state_o;
    logic           core_CF;
    logic           out_valid;
    logic           out_ready;
    logic [CHW-1:0] out_ch;
    logic [127:0]   out_data;
    logic           busy;
    logic           timeout;

    aes_mode_sequencer #(.NCH(NCH), .FIFO_DEPTH(4), .CTR_W(32), .TIMEOUT(64)) dut (
        .CLK(CLK), .CLR_N(CLR_N),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_enc_dec(cfg_enc_dec),
        .cfg_iv(cfg_iv), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .core_go(core_go), .core_enc_dec(core_enc_dec), .core_state_i(core_state_i),
        .core_state_o(core_state_o), .core_CF(core_CF),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
        .busy(busy), .timeout(timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {logic [CHW-1:0] ch; logic [127:0] data;} out_t;
    typedef struct packed {logic [127:0] cin; logic dir;} core_t;

    out_t  sb_q[$];
    core_t core_q[$];
    out_t  mon_exp;
    core_t cm_exp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]   m_mode  [NCH];
    logic         m_dir   [NCH];
    logic [127:0] m_chain [NCH];

    int   core_lat  = 1;
    bit   core_mute = 1'b0;
    int   rst_cnt   = 0;
    logic [127:0] cm_cin;
    logic         cm_dir;
    int           cm_snap;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] toy_core(input logic [127:0] x, input logic enc);
        logic [127:0] y;
        if (enc && x == KAT_P) return KAT_C;
        if (!enc && x == KAT_C) return KAT_P;
        if (enc) return {x[119:0], x[127:120]} ^ TOY_K;
        y = x ^ TOY_K;
        return {y[7:0], y[127:8]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_mode[i]  = 2'b00;
            m_dir[i]   = 1'b1;
            m_chain[i] = '0;
        end
    endtask

    // Cipher core stand-in: checks the block it is handed, answers core_lat cycles later.
    initial begin
        core_CF      = 1'b0;
        core_state_o = '0;
        forever begin
            @(negedge CLK);
            if (core_go) begin
                cm_cin  = core_state_i;
                cm_dir  = core_enc_dec;
                cm_snap = rst_cnt;
                if (core_q.size() == 0) begin
                    check_val("core_unexpected_go", 128'(1), 128'(0));
                end else begin
                    cm_exp = core_q.pop_front();
                    check_val("core_state_i", cm_cin, cm_exp.cin);
                    check_val("core_enc_dec", 128'(cm_dir), 128'(cm_exp.dir));
                end
                repeat (core_lat) @(negedge CLK);
                if (!core_mute) begin
                    if (rst_cnt == cm_snap) check_val("core_in_hold", core_state_i, cm_cin);
                    core_state_o = toy_core(cm_cin, cm_dir);
                    core_CF      = 1'b1;
                    @(negedge CLK);
                    core_CF      = 1'b0;
                    core_state_o = '0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (CLR_N && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("out_unexpected", 128'(1), 128'(0));
            end else begin
                mon_exp = sb_q.pop_front();
                check_val("out_data", out_data, mon_exp.data);
                check_val("out_ch", 128'(out_ch), 128'(mon_exp.ch));
            end
        end
    end

    task automatic cfg_write(input logic [CHW-1:0] ch, input logic [1:0] mode, input logic dir,
                             input logic [127:0] iv, input logic rej);
        @(posedge CLK); #1;
        cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_enc_dec = dir; cfg_iv = iv;
        @(posedge CLK); #1;
        cfg_we = 1'b0;
        @(negedge CLK);
        check_val("cfg_err", 128'(cfg_err), 128'(rej));
        if (!rej) begin
            m_mode[ch] = mode; m_dir[ch] = dir; m_chain[ch] = iv;
        end
    endtask

    task automatic send(input logic [CHW-1:0] ch, input logic [127:0] d, input bit expect_out);
        logic [1:0]   md;
        logic         dr;
        logic [127:0] cv, cin, res;
        bit           got;
        md = (m_mode[ch] == 2'b11) ? 2'b00 : m_mode[ch];
        dr = m_dir[ch];
        cv = m_chain[ch];
        case (md)
            2'b01: begin
                if (dr) begin
                    cin = d ^ cv; res = toy_core(cin, 1'b1);
                    if (expect_out) m_chain[ch] = res;
                end else begin
                    cin = d; res = toy_core(d, 1'b0) ^ cv;
                    if (expect_out) m_chain[ch] = d;
                end
            end
            2'b10: begin
                cin = cv; dr = 1'b1; res = toy_core(cv, 1'b1) ^ d;
                if (expect_out) m_chain[ch] = {cv[127:32], cv[31:0] + 32'd1};
            end
            default: begin
                cin = d; res = toy_core(d, dr);
            end
        endcase
        core_q.push_back({cin, dr});
        if (expect_out) sb_q.push_back({ch, res});
        @(posedge CLK); #1;
        in_valid = 1'b1; in_ch = ch; in_data = d;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (in_ready) begin got = 1'b1; break; end
        end
        if (!got) check_val("in_accept_timeout", 128'(0), 128'(1));
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (!busy && !out_valid && sb_q.size() == 0 && core_q.size() == 0) begin
                done = 1'b1; break;
            end
        end
        if (!done) check_val("drain_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] p1, p2, c1, c2, ctr_iv;
        int           bad;
        bit           seen;
        CLR_N = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_enc_dec = 1'b0; cfg_iv = '0;
        in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_core_go", 128'(core_go), 128'(0));
        check_val("rst_cfg_err", 128'(cfg_err), 128'(0));
        check_val("rst_timeout", 128'(timeout), 128'(0));
        check_val("rst_core_state_i", core_state_i, 128'(0));
        check_val("rst_out_data", out_data, 128'(0));
        @(posedge CLK); #1;
        CLR_N = 1'b1;

        // ECB known-answer block on channel 0, plus go latency
        out_ready = 1'b1;
        send(1'b0, KAT_P, 1'b1);
        @(negedge CLK);
        check_val("core_go_latency", 128'(core_go), 128'(1));
        wait_drain();

        // CBC encrypt then decrypt on channel 1
        p1 = 128'h00112233445566778899AABBCCDDEEFF;
        p2 = 128'hFFEEDDCCBBAA99887766554433221100;
        cfg_write(1'b1, 2'b01, 1'b1, '0, 1'b0);
        send(1'b1, p1, 1'b1);
        c1 = m_chain[1];
        send(1'b1, p2, 1'b1);
        c2 = m_chain[1];
        wait_drain();
        cfg_write(1'b1, 2'b01, 1'b0, '0, 1'b0);
        send(1'b1, c1, 1'b1);
        send(1'b1, c2, 1'b1);
        wait_drain();

        // CTR with low-word wrap on channel 0
        ctr_iv = 128'hA5A5A5A5_5A5A5A5A_00000000_FFFFFFFF;
        cfg_write(1'b0, 2'b10, 1'b0, ctr_iv, 1'b0);
        send(1'b0, rnd128(), 1'b1);
        send(1'b0, rnd128(), 1'b1);
        send(1'b0, rnd128(), 1'b1);
        wait_drain();

        // Reserved mode behaves as ECB
        cfg_write(1'b1, 2'b11, 1'b0, rnd128(), 1'b0);
        send(1'b1, rnd128(), 1'b1);
        wait_drain();

        // FIFO fill with consumer stalled
        cfg_write(1'b0, 2'b00, 1'b1, '0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, rnd128(), 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (!busy) begin seen = 1'b1; break; end
        end
        check_val("full_idle_reached", 128'(seen), 128'(1));
        check_val("full_in_ready", 128'(in_ready), 128'(0));
        check_val("full_out_valid", 128'(out_valid), 128'(1));
        @(posedge CLK); #1;
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        @(negedge CLK);
        check_val("after_pop_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        wait_drain();

        // Config writes while a block is waiting on the core
        cfg_write(1'b0, 2'b01, 1'b1, rnd128(), 1'b0);
        core_lat = 10;
        send(1'b0, rnd128(), 1'b1);
        cfg_write(1'b0, 2'b00, 1'b0, rnd128(), 1'b1);
        @(negedge CLK);
        check_val("cfg_err_one_cycle", 128'(cfg_err), 128'(0));
        cfg_write(1'b1, 2'b00, 1'b0, rnd128(), 1'b0);
        check_val("busy_during_cfg", 128'(busy), 128'(1));
        wait_drain();
        core_lat = 1;
        send(1'b0, rnd128(), 1'b1);
        send(1'b1, KAT_C, 1'b1);
        wait_drain();

        // Reset while waiting on the core; late completion must be ignored
        core_lat = 8;
        send(1'b0, rnd128(), 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        CLR_N = 1'b0;
        rst_cnt++;
        #1;
        check_val("midrst_busy", 128'(busy), 128'(0));
        check_val("midrst_core_go", 128'(core_go), 128'(0));
        check_val("midrst_out_valid", 128'(out_valid), 128'(0));
        check_val("midrst_core_state_i", core_state_i, 128'(0));
        check_val("midrst_core_enc_dec", 128'(core_enc_dec), 128'(0));
        model_reset();
        sb_q.delete();
        @(posedge CLK); #1;
        CLR_N = 1'b1;
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            if (out_valid || busy) bad++;
        end
        check_val("stale_cf_ignored", 128'(bad), 128'(0));
        core_lat = 1;
        send(1'b0, KAT_P, 1'b1);
        wait_drain();

`ifdef AES_SEQ_TIMEOUT_EN
        // Core never answers: watchdog drops the block
        core_mute = 1'b1;
        send(1'b1, rnd128(), 1'b0);
        seen = 1'b0;
        bad  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (timeout) begin seen = 1'b1; bad = i; break; end
        end
        check_val("timeout_seen", 128'(seen), 128'(1));
        check_val("timeout_cycle", 128'(bad), 128'(65));
        check_val("timeout_busy", 128'(busy), 128'(0));
        check_val("timeout_no_push", 128'(out_valid), 128'(0));
        @(negedge CLK);
        check_val("timeout_pulse_width", 128'(timeout), 128'(0));
        repeat (4) @(negedge CLK);
        core_mute = 1'b0;
`endif

        wait_drain();
        check_val("final_timeout_low", 128'(timeout), 128'(0));
        check_val("final_sb_empty", 128'(sb_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
